// File: rtl/adc_if_pkg.sv
// Shared types and parameter helpers for the SAR ADC master controller.
// Holds the FSM state encoding and the clock-divider derivations.
package adc_if_pkg;

    localparam int DATA_W_DEFAULT = 24;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        WAIT_BUSY,
        READ,
        DONE,
        HOLD
    } adc_state_t;

    function automatic int calc_smpl_div(input int clk_freq, input int smpl_freq);
        return clk_freq / smpl_freq;
    endfunction

    // SCK half-period in clk cycles; never below one cycle.
    function automatic int calc_sck_half(input int clk_freq, input int spi_freq);
        int half;
        half = clk_freq / (2 * spi_freq);
        return (half < 1) ? 1 : half;
    endfunction

endpackage

// File: rtl/adc_interface_if.sv
// ADC pin bundle between the conversion controller (master) and the converter (slave).
interface adc_interface_if;
    logic o_start_conv;
    logic o_sck;
    logic o_RDL_SDI;
    logic o_chain;
    logic i_busy;
    logic i_data_in;

    modport master (
        output o_start_conv, o_sck, o_RDL_SDI, o_chain,
        input  i_busy, i_data_in
    );

    modport slave (
        input  o_start_conv, o_sck, o_RDL_SDI, o_chain,
        output i_busy, i_data_in
    );
endinterface

// File: rtl/adc_sck_gen.sv
// SCK divider for the ADC read phase: low-then-high half periods, rise/fall
// enables aligned with the clk edge that moves SCK, and an N_BITS period counter.
module adc_sck_gen #(
    parameter int SCK_HALF = 3,
    parameter int N_BITS   = 24
) (
    input  logic clk,
    input  logic i_reset,
    input  logic run,
    output logic sck,
    output logic rise_en,
    output logic fall_en,
    output logic last_bit
);
    localparam int HW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam int BW = (N_BITS > 1) ? $clog2(N_BITS + 1) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(SCK_HALF - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(N_BITS - 1);

    logic [HW-1:0] half_cnt;
    logic [BW-1:0] bit_cnt;
    logic          half_end;

    assign half_end = run && (half_cnt == HALF_LAST);
    assign rise_en  = half_end && !sck;
    assign fall_en  = half_end && sck;
    assign last_bit = (bit_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (i_reset || !run) begin
            half_cnt <= '0;
            bit_cnt  <= '0;
            sck      <= 1'b0;
        end else if (half_end) begin
            half_cnt <= '0;
            sck      <= !sck;
            if (sck) bit_cnt <= bit_cnt + 1'b1;
        end else begin
            half_cnt <= half_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/adc_interface.sv
// Master-side controller for a 24-bit SAR ADC: periodic CNV, BUSY wait, serial readout.
// Optional build macro ADC_BUSY_TIMEOUT_EN abandons a frame whose BUSY never completes.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | SDO disabled (RDL high), waiting for read enable
//  CONV      | CNV high for CNV_HIGH cycles, sample period starts
//  WAIT_BUSY | waiting for synchronised BUSY to go high and then low
//  READ      | 24 SCK periods, data shifted in on each SCK rise
//  DONE      | word published, data_ready high for one cycle
//  HOLD      | waiting out the rest of the sample period
module adc_interface
    import adc_if_pkg::*;
#(
    parameter int CLK_FREQ     = 25_000_000,
    parameter int SMPL_FREQ    = 48_000,
    parameter int SPI_CLK_FREQ = 4_000_000,
    parameter int CNV_HIGH     = 2,
    parameter int DATA_W       = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_read_enable,
    adc_interface_if.master   adc,
    output logic [DATA_W-1:0] o_data_frame,
    output logic              data_ready
);
    localparam int SMPL_DIV = calc_smpl_div(CLK_FREQ, SMPL_FREQ);
    localparam int SCK_HALF = calc_sck_half(CLK_FREQ, SPI_CLK_FREQ);
    localparam int SMPL_W   = (SMPL_DIV > 1) ? $clog2(SMPL_DIV) : 1;
    localparam logic [SMPL_W-1:0] SMPL_LAST = SMPL_W'(SMPL_DIV - 1);
    localparam logic [SMPL_W-1:0] CNV_LAST  = SMPL_W'(CNV_HIGH - 1);

    adc_state_t        state, state_next;
    logic [SMPL_W-1:0] smpl_cnt;
    logic              busy_s1, busy_s2, busy_seen;
    logic [DATA_W-1:0] shift_reg;
    logic              conv_entry, period_end;
    logic              sck, rise_en, fall_en, last_bit, read_done;

    assign conv_entry = (state_next == CONV) && (state != CONV);
    assign period_end = (smpl_cnt == SMPL_LAST);
    assign read_done  = fall_en && last_bit;

    adc_sck_gen #(
        .SCK_HALF (SCK_HALF),
        .N_BITS   (DATA_W)
    ) u_sck_gen (
        .clk      (clk),
        .i_reset  (i_reset),
        .run      (state == READ),
        .sck      (sck),
        .rise_en  (rise_en),
        .fall_en  (fall_en),
        .last_bit (last_bit)
    );

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_read_enable) state_next = CONV;
            end
            CONV: begin
                if (smpl_cnt == CNV_LAST) state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (busy_seen && !busy_s2) begin
                    state_next = READ;
                end
`ifdef ADC_BUSY_TIMEOUT_EN
                else if (period_end) begin
                    state_next = i_read_enable ? CONV : IDLE;
                end
`endif
            end
            READ: begin
                if (read_done) state_next = DONE;
            end
            // An overrunning frame skips HOLD so the next CNV follows DONE directly.
            DONE: begin
                if (period_end) state_next = i_read_enable ? CONV : IDLE;
                else            state_next = HOLD;
            end
            HOLD: begin
                if (period_end) state_next = i_read_enable ? CONV : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Sample period counter saturates so a late frame never wraps it.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            smpl_cnt <= '0;
        end else if (conv_entry) begin
            smpl_cnt <= '0;
        end else if (!period_end) begin
            smpl_cnt <= smpl_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            busy_s1   <= 1'b0;
            busy_s2   <= 1'b0;
            busy_seen <= 1'b0;
        end else begin
            busy_s1 <= adc.i_busy;
            busy_s2 <= busy_s1;
            if (conv_entry) begin
                busy_seen <= 1'b0;
            end else if ((state == CONV || state == WAIT_BUSY) && busy_s2) begin
                busy_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            shift_reg    <= '0;
            o_data_frame <= '0;
        end else begin
            if (rise_en) shift_reg <= {shift_reg[DATA_W-2:0], adc.i_data_in};
            if (state == READ && read_done) o_data_frame <= shift_reg;
        end
    end

    assign data_ready       = (state == DONE);
    assign adc.o_start_conv = (state == CONV);
    assign adc.o_RDL_SDI    = (state == IDLE);
    assign adc.o_sck        = sck;
    assign adc.o_chain      = 1'b0;
endmodule

// File: tb/tb_adc_interface.sv
// Scoreboard bench for adc_interface: a behavioural ADC serves queued words,
// expected words are queued at CNV and compared at each data_ready.
module tb_adc_interface;
    localparam int SMPL_DIV = 520;

    logic        clk;
    logic        i_reset;
    logic        i_read_enable;
    logic [23:0] o_data_frame;
    logic        data_ready;

    adc_interface_if adc_bus ();

    adc_interface dut (
        .clk           (clk),
        .i_reset       (i_reset),
        .i_read_enable (i_read_enable),
        .adc           (adc_bus),
        .o_data_frame  (o_data_frame),
        .data_ready    (data_ready)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [23:0] stim_q[$];
    logic [23:0] exp_q[$];
    logic        drop_next  = 1'b0;
    logic        drop_all   = 1'b0;
    logic        busy_stuck = 1'b0;
    logic        period_chk = 1'b0;

    // Behavioural ADC: BUSY for 200 ns after CNV, MSB on SDO when BUSY falls,
    // next bit shortly after each SCK rise.
    initial begin
        logic [23:0] w;
        adc_bus.i_busy    = 1'b0;
        adc_bus.i_data_in = 1'b0;
        forever begin
            @(posedge adc_bus.o_start_conv);
            w = (stim_q.size() > 0) ? stim_q.pop_front() : 24'h0;
            if (!drop_all && !drop_next) exp_q.push_back(w);
            drop_next = 1'b0;
            #10 adc_bus.i_busy = 1'b1;
            if (busy_stuck) begin
                wait (!busy_stuck);
                adc_bus.i_busy = 1'b0;
                continue;
            end
            #200 adc_bus.i_busy = 1'b0;
            adc_bus.i_data_in = w[23];
            for (int b = 22; b >= 0; b--) begin
                @(posedge adc_bus.o_sck or posedge i_reset);
                if (i_reset) break;
                #5 adc_bus.i_data_in = w[b];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int cnv_rises = 0, sck_rises = 0, ready_cnt = 0;
    int cnv_w = 0, sck_w = 0, dr_w = 0, sck_frame = 0, last_rise = 0;
    logic have_rise = 1'b0;

    initial begin
        logic p_cnv, p_sck, p_dr;
        logic [23:0] e;
        p_cnv = 1'b0; p_sck = 1'b0; p_dr = 1'b0;
        forever begin
            @(negedge clk);
            if (i_reset) begin
                cnv_w = 0; sck_w = 0; dr_w = 0;
            end else begin
                if (adc_bus.o_start_conv) begin
                    if (!p_cnv) begin
                        if (period_chk && have_rise) check_val("cnv_period", 32'(cyc - last_rise), 32'(SMPL_DIV));
                        last_rise = cyc; have_rise = 1'b1; cnv_rises++; sck_frame = 0;
                    end
                    cnv_w++;
                end else if (p_cnv) begin
                    check_val("cnv_width", 32'(cnv_w), 32'd2);
                    cnv_w = 0;
                end
                if (adc_bus.o_sck) begin
                    if (!p_sck) begin sck_rises++; sck_frame++; end
                    sck_w++;
                end else if (p_sck) begin
                    check_val("sck_high_width", 32'(sck_w), 32'd3);
                    sck_w = 0;
                end
                if (data_ready) begin
                    ready_cnt++; dr_w++;
                    check_val("sck_per_frame", 32'(sck_frame), 32'd24);
                    check_val("exp_avail", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check_val("frame", 32'(o_data_frame), 32'(e));
                    end
                end else if (p_dr) begin
                    check_val("ready_width", 32'(dr_w), 32'd1);
                    dr_w = 0;
                end
            end
            p_cnv = adc_bus.o_start_conv; p_sck = adc_bus.o_sck; p_dr = data_ready;
        end
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin @(negedge clk); #1; end
    endtask

    task automatic wait_ready(input int target, input int budget, input string tag);
        int n = 0;
        while (ready_cnt < target && n < budget) begin @(negedge clk); #1; n++; end
        if (ready_cnt < target) check_val(tag, 32'(ready_cnt), 32'(target));
    endtask

    task automatic wait_cnv(input int target, input int budget, input string tag);
        int n = 0;
        while (cnv_rises < target && n < budget) begin @(negedge clk); #1; n++; end
        if (cnv_rises < target) check_val(tag, 32'(cnv_rises), 32'(target));
    endtask

    task automatic wait_sck(input int target, input int budget, input string tag);
        int n = 0;
        while (sck_rises < target && n < budget) begin @(negedge clk); #1; n++; end
        if (sck_rises < target) check_val(tag, 32'(sck_rises), 32'(target));
    endtask

    initial begin
        int base_r, base_c, base_s;
        i_reset = 1'b1;
        i_read_enable = 1'b0;
        #50 i_reset = 1'b0;

        // reset state, no CNV while disabled
        @(negedge clk); #1;
        check_val("rst_cnv",   32'(adc_bus.o_start_conv), 32'd0);
        check_val("rst_sck",   32'(adc_bus.o_sck), 32'd0);
        check_val("rst_rdl",   32'(adc_bus.o_RDL_SDI), 32'd1);
        check_val("rst_chain", 32'(adc_bus.o_chain), 32'd0);
        check_val("rst_frame", 32'(o_data_frame), 32'd0);
        check_val("rst_ready", 32'(data_ready), 32'd0);
        idle_cycles(600);
        check_val("idle_no_cnv", 32'(cnv_rises), 32'd0);

        // single frame
        stim_q.push_back(24'hA5C3F1);
        i_read_enable = 1'b1;
        wait_cnv(1, 20, "single_cnv_timeout");
        i_read_enable = 1'b0;
        wait_ready(1, 1000, "single_ready_timeout");
        idle_cycles(700);
        check_val("single_rdl_idle", 32'(adc_bus.o_RDL_SDI), 32'd1);
        check_val("single_cnv_count", 32'(cnv_rises), 32'd1);

        // continuous frames, then enable dropped during the fourth readout
        base_r = ready_cnt; base_c = cnv_rises;
        stim_q.push_back(24'h800000);
        stim_q.push_back(24'h7FFFFF);
        stim_q.push_back(24'h000001);
        stim_q.push_back(24'h123456);
        i_read_enable = 1'b1;
        wait_cnv(base_c + 1, 20, "cont_cnv_timeout");
        period_chk = 1'b1;
        wait_ready(base_r + 3, 2000, "cont_ready_timeout");
        base_s = sck_rises;
        wait_sck(base_s + 1, 700, "drop_sck_timeout");
        i_read_enable = 1'b0;
        wait_ready(base_r + 4, 700, "drop_ready_timeout");
        period_chk = 1'b0;
        idle_cycles(800);
        check_val("drop_cnv_count", 32'(cnv_rises), 32'(base_c + 4));
        check_val("drop_rdl_idle", 32'(adc_bus.o_RDL_SDI), 32'd1);
        check_val("drop_last_frame", 32'(o_data_frame), 32'h123456);

        // reset during bit 10 of a readout
        base_r = ready_cnt; base_s = sck_rises;
        stim_q.push_back(24'h5A5A5A);
        drop_next = 1'b1;
        i_read_enable = 1'b1;
        wait_sck(base_s + 10, 800, "rst_mid_sck_timeout");
        i_reset = 1'b1;
        i_read_enable = 1'b0;
        @(negedge clk); #1;
        check_val("rst_mid_sck",   32'(adc_bus.o_sck), 32'd0);
        check_val("rst_mid_ready", 32'(data_ready), 32'd0);
        check_val("rst_mid_frame", 32'(o_data_frame), 32'd0);
        check_val("rst_mid_rdl",   32'(adc_bus.o_RDL_SDI), 32'd1);
        @(negedge clk); #1;
        i_reset = 1'b0;
        idle_cycles(700);
        check_val("rst_mid_no_ready", 32'(ready_cnt), 32'(base_r));

        // BUSY stuck high
        base_r = ready_cnt; base_c = cnv_rises; base_s = sck_rises;
        busy_stuck = 1'b1;
        drop_all = 1'b1;
        i_read_enable = 1'b1;
        wait_cnv(base_c + 1, 20, "stuck_cnv_timeout");
`ifdef ADC_BUSY_TIMEOUT_EN
        period_chk = 1'b1;
        idle_cycles(1500);
        check_val("stuck_cnv_count", 32'(cnv_rises), 32'(base_c + 3));
`else
        idle_cycles(1500);
        check_val("stuck_cnv_count", 32'(cnv_rises), 32'(base_c + 1));
        check_val("stuck_rdl_busy",  32'(adc_bus.o_RDL_SDI), 32'd0);
`endif
        check_val("stuck_no_sck",   32'(sck_rises), 32'(base_s));
        check_val("stuck_no_ready", 32'(ready_cnt), 32'(base_r));
        check_val("stuck_frame",    32'(o_data_frame), 32'd0);
        period_chk = 1'b0;
        i_reset = 1'b1;
        i_read_enable = 1'b0;
        busy_stuck = 1'b0;
        idle_cycles(3);
        i_reset = 1'b0;
        drop_all = 1'b0;
        idle_cycles(10);

        check_val("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
